regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised 2-read/1-write register file with an integrated per-register busy scoreboard, replacing the fixed 8×32 register set in the datapath. It holds architectural registers, provides combinational reads with optional write-to-read bypass, and tracks which registers have an outstanding producer so the control unit can detect RAW hazards. It sits between decode (read and reserve ports) and writeback (write port).

## Interface

- WIDTH, 32, data width of each register
- DEPTH, 8, number of registers, 2..32; address width AW = $clog2(DEPTH)
- ZERO_REG, 0, 1: register 0 is hardwired to zero, never written, never busy
- BYPASS, 1, 1: same-cycle write data and busy-clear are forwarded to the read ports

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- A1  in  AW  read address, port 1
- A2  in  AW  read address, port 2
- A3  in  AW  write address
- WE3  in  1  write enable
- WD3  in  WIDTH  write data
- RSV  in  1  reserve enable: mark RA busy
- RA  in  AW  reserve address
- RD1  out  WIDTH  read data, port 1
- RD2  out  WIDTH  read data, port 2
- BUSY1  out  1  register A1 has an outstanding producer
- BUSY2  out  1  register A2 has an outstanding producer
- PCOUNT  out  $clog2(DEPTH+1)  number of currently busy registers

## Operation

- Storage: DEPTH registers of WIDTH bits plus DEPTH busy bits.
- Address valid iff addr < DEPTH and not (ZERO_REG and addr == 0). Invalid write and reserve addresses are ignored.
- Write: WE3 with valid A3 loads WD3 into reg[A3] and clears busy[A3].
- Reserve: RSV with valid RA sets busy[RA].
- Simultaneous write and reserve to the same address: data is written, and busy ends at 1 (the reserve belongs to a newer producer).
- Read: RDn = reg[An]. If An >= DEPTH, or ZERO_REG and An == 0, RDn = 0.
- BYPASS=1 and WE3 with valid A3 == An: RDn = WD3.
- BUSYn = busy[An], 0 for invalid addresses.
- BYPASS=1 and WE3 with valid A3 == An: BUSYn = 0, unless RSV with RA == An is asserted in the same cycle, in which case BUSYn = 1.
- Reserve is never bypassed: a same-cycle RSV does not affect BUSYn except in the write-collision case above.
- PCOUNT: registered population count of the busy bits, updated incrementally each edge.
  - +1 when a reserve sets a bit that was 0.
  - −1 when a write clears a bit that was 1 without a same-address reserve.
  - Both on different addresses: net 0.
  - Never exceeds DEPTH − ZERO_REG.
- Reserving an already-busy register leaves it busy, with no PCOUNT change.
- Writing a non-busy register is legal: data updates, PCOUNT unchanged.

## Timing

- Reset: on RST assertion all registers = 0, all busy bits = 0, PCOUNT = 0 immediately, without waiting for CLK. While RST is high, RD1/RD2 = 0 (or WD3 via bypass), BUSY1/BUSY2 = 0, and writes and reserves are ignored.
- Reset mid-operation: any pending reservation is lost. Writes that coincide with the deassertion edge are not guaranteed.
- Write latency: 1 cycle. Without bypass, data is visible on RDn the cycle after the WE3 edge. With BYPASS=1 it is visible combinationally in the same cycle.
- Reserve latency: BUSYn rises the cycle after the RSV edge.
- PCOUNT reflects state after the most recent edge, with zero combinational paths from inputs.
- Read paths RDn and BUSYn are purely combinational from addresses and the bypass inputs. No handshake.

## Test plan

- Reset then read all: assert RST mid-cycle after writing reg3=0xDEADBEEF -> RD1 with A1=3 reads 0 asynchronously; PCOUNT=0; all BUSY=0.
- Write/read with bypass: WE3=1, A3=5, WD3=0x12345678, A1=5 -> RD1=0x12345678 in the same cycle (BYPASS=1). With BYPASS=0, RD1 = old value that cycle and 0x12345678 the next cycle.
- Scoreboard lifecycle: RSV RA=2 -> next cycle BUSY2(A2=2)=1, PCOUNT=1. Write A3=2, WD3=0xA5 -> BUSY2=0 that cycle (bypass), busy clear after the edge, PCOUNT=0.
- Collision: reg4 busy, then same cycle WE3 A3=4 and RSV RA=4 -> reg4 = new data, busy stays 1, PCOUNT unchanged at 1.
- Concurrent different addresses: reg1 busy; same cycle write A3=1 and RSV RA=6 -> PCOUNT stays 1, busy moves 1->6.
- ZERO_REG=1, DEPTH=5: write A3=0, WD3=0xFF -> RD1(A1=0)=0. RSV RA=0 -> BUSY1=0, PCOUNT=0. A1=7 -> RD1=0, BUSY1=0. Reserving all of 1..4 -> PCOUNT=4.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a per-register busy scoreboard.
// Reads and busy lookups are combinational; the busy population count is registered.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_a1,
  input  logic [AW-1:0]    i_a2,
  input  logic [AW-1:0]    i_a3,
  input  logic             i_we3,
  input  logic [WIDTH-1:0] i_wd3,
  input  logic             i_rsv,
  input  logic [AW-1:0]    i_ra,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  output logic             o_busy1,
  output logic             o_busy2,
  output logic [PW-1:0]    o_pcount
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [PW-1:0]    r_pcount;

  logic             w_we_ok;
  logic             w_rsv_ok;
  logic             w_a3_busy;
  logic             w_ra_busy;
  logic             w_inc;
  logic             w_dec;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW-1:0]    w_addr [2];
  logic [WIDTH-1:0] w_lk_rd [2];
  logic [1:0]       w_lk_busy;
  logic [WIDTH-1:0] w_rd [2];
  logic [1:0]       w_busy_out;

  function automatic logic addr_ok(input logic [AW-1:0] addr);
    addr_ok = ({1'b0, addr} < (AW+1)'(DEPTH)) &&
              !(ZERO_REG && (addr == {AW{1'b0}}));
  endfunction

  assign w_we_ok   = i_we3 && addr_ok(i_a3);
  assign w_rsv_ok  = i_rsv && addr_ok(i_ra);
  assign w_addr[0] = i_a1;
  assign w_addr[1] = i_a2;

  // Next busy vector and the pre-edge busy state of the write and reserve targets.
  always_comb begin
    w_busy_nxt = {DEPTH{1'b0}};
    w_a3_busy  = 1'b0;
    w_ra_busy  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy_nxt[i] = (r_busy[i] & ~(w_we_ok & (i_a3 == AW'(i)))) |
                      (w_rsv_ok & (i_ra == AW'(i)));
      w_a3_busy     = w_a3_busy | (r_busy[i] & (i_a3 == AW'(i)));
      w_ra_busy     = w_ra_busy | (r_busy[i] & (i_ra == AW'(i)));
    end
  end

  // A reserve on the write address wins, so that write never decrements the count.
  assign w_inc = w_rsv_ok && !w_ra_busy;
  assign w_dec = w_we_ok && w_a3_busy && !(w_rsv_ok && (i_ra == i_a3));

  // Register storage; an invalid write address, including the hardwired zero register, is never written.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_we_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_a3 == AW'(i)) begin
          r_mem[i] <= i_wd3;
        end
      end
    end
  end

  // Busy bits and their incrementally maintained population count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy   <= {DEPTH{1'b0}};
      r_pcount <= {PW{1'b0}};
    end else begin
      r_busy   <= w_busy_nxt;
      r_pcount <= r_pcount + PW'(w_inc) - PW'(w_dec);
    end
  end

  // Read ports: stored lookup, overridden by the same-cycle write when bypassing.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_lk_rd[p]    = {WIDTH{1'b0}};
      w_lk_busy[p]  = 1'b0;
      w_rd[p]       = {WIDTH{1'b0}};
      w_busy_out[p] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        w_lk_rd[p]   = w_lk_rd[p] | ((w_addr[p] == AW'(i)) ? r_mem[i] : {WIDTH{1'b0}});
        w_lk_busy[p] = w_lk_busy[p] | ((w_addr[p] == AW'(i)) & r_busy[i]);
      end
      if (BYPASS && w_we_ok && (i_a3 == w_addr[p])) begin
        w_rd[p]       = i_wd3;
        w_busy_out[p] = !i_rst && w_rsv_ok && (i_ra == w_addr[p]);
      end else if (addr_ok(w_addr[p])) begin
        w_rd[p]       = w_lk_rd[p];
        w_busy_out[p] = !i_rst && w_lk_busy[p];
      end else begin
        w_rd[p]       = {WIDTH{1'b0}};
        w_busy_out[p] = 1'b0;
      end
    end
  end

  assign o_rd1    = w_rd[0];
  assign o_rd2    = w_rd[1];
  assign o_busy1  = w_busy_out[0];
  assign o_busy2  = w_busy_out[1];
  assign o_pcount = r_pcount;

endmodule
